// File: rtl/seq_muldiv.sv
// Iterative signed 16x16 multiply / 16/16 divide (shift-add and restoring), one op at a time.
// Latency: start at edge 0 -> busy from edge 1 -> done pulse at edge WIDTH+2; special divides finish at edge 2.
// Backpressure: start is honoured only in IDLE; pulses while busy or in DONE are dropped, so the pipeline stalls on busy.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request (op 0 = signed mul, 1 = signed div), sampled in IDLE only
//   in1, in2          multiplicand/dividend, multiplier/divisor (two's complement)
//   busy, done        busy in RUN/FIX; one-cycle done pulse with results valid
//   result_hi/lo      product[2W-1:W]/[W-1:0], or remainder/quotient
//   div_zero, ovf     divide-by-zero and most-negative / -1 flags, valid with done
module seq_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0]   ONE_W    = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W   = 1;
    localparam logic [CNT_W-1:0]   ONE_C    = 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_q;
    logic               s1_q;
    logic               s2_q;
    logic               spec_q;     // result already set in IDLE, FIX must leave it alone
    logic [WIDTH-1:0]   m_q;        // multiplicand magnitude (mul) or divisor magnitude (div)
    // Accumulator, 2W+1 bits.
    // mul: {carry, partial product hi, multiplier bits shifting out / product lo}
    // div: {partial remainder (W+1), dividend bits shifting out / quotient bits shifting in}
    logic [2*WIDTH:0]   p_q;
    logic [WIDTH-1:0]   res_hi_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic               dz_q;
    logic               ov_q;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        // Magnitude of the most-negative value wraps to itself, which is the correct unsigned value.
        abs1 = in1[WIDTH-1] ? (~in1 + ONE_W) : in1;
        abs2 = in2[WIDTH-1] ? (~in2 + ONE_W) : in2;

        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        mul_next = {1'b0, mul_sum, p_q[WIDTH-1:1]};

        // Shift the remainder/dividend pair left, try subtracting the divisor; a borrow in the
        // top bit means restore (keep the shifted value) and record a 0 quotient bit.
        div_sh    = {p_q[2*WIDTH-1:0], 1'b0};
        div_trial = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, m_q};
        div_next  = div_trial[WIDTH+1] ? div_sh
                                       : {div_trial[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};

        prod     = p_q[2*WIDTH-1:0];
        prod_neg = ~prod + ONE_2W;
        quo      = p_q[WIDTH-1:0];
        rem      = p_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            spec_q    <= 1'b0;
            m_q       <= '0;
            p_q       <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            // Outputs lag the state by one edge: busy reflects RUN/FIX, done reflects DONE.
            busy <= (state == RUN) || (state == FIX);
            done <= (state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        s1_q     <= in1[WIDTH-1];
                        s2_q     <= in2[WIDTH-1];
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                        if (op && (in2 == '0)) begin
                            dz_q     <= 1'b1;
                            ov_q     <= 1'b0;
                            spec_q   <= 1'b1;
                            res_lo_q <= '1;
                            res_hi_q <= in1;
                            state    <= FIX;
                        end else if (op && (in1 == MOST_NEG) && (in2 == '1)) begin
                            dz_q     <= 1'b0;
                            ov_q     <= 1'b1;
                            spec_q   <= 1'b1;
                            res_lo_q <= MOST_NEG;
                            res_hi_q <= '0;
                            state    <= FIX;
                        end else begin
                            dz_q   <= 1'b0;
                            ov_q   <= 1'b0;
                            spec_q <= 1'b0;
                            m_q    <= op ? abs2 : abs1;
                            p_q    <= {{(WIDTH+1){1'b0}}, (op ? abs1 : abs2)};
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    p_q <= op_q ? div_next : mul_next;
                    cnt <= cnt + ONE_C;
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!spec_q) begin
                        if (op_q) begin
                            res_lo_q <= (s1_q ^ s2_q) ? (~quo + ONE_W) : quo;
                            // Remainder follows the dividend sign (truncating division).
                            res_hi_q <= s1_q ? (~rem + ONE_W) : rem;
                        end else begin
                            {res_hi_q, res_lo_q} <= (s1_q ^ s2_q) ? prod_neg : prod;
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    result_hi <= res_hi_q;
                    result_lo <= res_lo_q;
                    div_zero  <= dz_q;
                    ovf       <= ov_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: hand-computed vectors checked with immediate assertions.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_seq_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_zero;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    seq_muldiv #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (edge 0), then scramble the operands.
    task automatic start_op(input logic o, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        tick();
        start = 1'b0;
        in1   = 16'hDEAD;
        in2   = 16'hBEEF;
    endtask

    // Returns the edge index (relative to the current one) at which done is seen, or -1.
    task automatic wait_done(output int lat, output int busy_low);
        lat      = -1;
        busy_low = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic do_op(input string nm, input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ehi, input logic [15:0] elo,
                         input logic edz, input logic eov, input int elat);
        int lat;
        int blo;
        start_op(o, a, b);
        wait_done(lat, blo);
        check({nm, " latency"}, 32'(lat), 32'(elat));
        check({nm, " busy gaps"}, 32'(blo), 32'd0);
        check({nm, " busy@done"}, {31'd0, busy}, 32'd0);
        check({nm, " hi"}, {16'd0, result_hi}, {16'd0, ehi});
        check({nm, " lo"}, {16'd0, result_lo}, {16'd0, elo});
        check({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eov});
        tick();
        check({nm, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int blo;
        int seen;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        in1   = 16'h0;
        in2   = 16'h0;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset results", {result_hi, result_lo}, 32'd0);
        check("reset flags", {30'd0, div_zero, ovf}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Multiply
        do_op("mul 7*-3",       1'b0, 16'h0007, 16'hFFFD, 16'hFFFF, 16'hFFEB, 1'b0, 1'b0, 18);
        do_op("mul 8000*8000",  1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 1'b0, 18);
        do_op("mul 0*-1",       1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 18);
        do_op("mul 3*-4",       1'b0, 16'h0003, 16'hFFFC, 16'hFFFF, 16'hFFF4, 1'b0, 1'b0, 18);

        // Divide
        do_op("div 100/7",      1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 1'b0, 18);
        do_op("div -100/7",     1'b1, 16'hFF9C, 16'h0007, 16'hFFFE, 16'hFFF2, 1'b0, 1'b0, 18);
        do_op("div 100/-7",     1'b1, 16'h0064, 16'hFFF9, 16'h0002, 16'hFFF2, 1'b0, 1'b0, 18);
        do_op("div -100/-7",    1'b1, 16'hFF9C, 16'hFFF9, 16'hFFFE, 16'h000E, 1'b0, 1'b0, 18);
        do_op("div 1234/0",     1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 2);
        do_op("div 8000/-1",    1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b1, 2);

        // Flags from the previous divide are cleared by the next accepted start.
        start_op(1'b0, 16'h0002, 16'h0002);
        check("flags cleared on start", {30'd0, div_zero, ovf}, 32'd0);
        wait_done(lat, blo);
        check("mul 2*2 lo", {16'd0, result_lo}, 32'h0000_0004);
        tick();

        // Start while busy is dropped; start in the DONE-state cycle is dropped too.
        start_op(1'b0, 16'h0005, 16'h0005);          // now just after edge 0
        repeat (4) tick();                           // after edge 4
        start = 1'b1; op = 1'b1; in1 = 16'h0064; in2 = 16'h0000;
        tick();                                      // edge 5
        start = 1'b0;
        seen = 0;
        for (int k = 6; k <= 17; k++) begin
            tick();
            if (!busy || done) seen++;
        end
        check("busy through interference", 32'(seen), 32'd0);
        start = 1'b1; op = 1'b0; in1 = 16'h0006; in2 = 16'h0006;
        tick();                                      // edge 18: DONE state, start ignored
        start = 1'b0;
        check("mul 5*5 done@18", {31'd0, done}, 32'd1);
        check("mul 5*5 lo", {16'd0, result_lo}, 32'h0000_0019);
        check("mul 5*5 hi", {16'd0, result_hi}, 32'd0);
        check("mul 5*5 div_zero", {31'd0, div_zero}, 32'd0);
        tick();
        check("start in DONE ignored busy@19", {31'd0, busy}, 32'd0);
        check("start in DONE ignored done@19", {31'd0, done}, 32'd0);
        tick();
        check("start in DONE ignored busy@20", {31'd0, busy}, 32'd0);
        do_op("mul 6*6 after DONE", 1'b0, 16'h0006, 16'h0006, 16'h0000, 16'h0024, 1'b0, 1'b0, 18);

        // Asynchronous reset mid-operation.
        start_op(1'b0, 16'h0009, 16'h0009);
        repeat (7) tick();                           // after edge 7
        @(posedge clk);                              // edge 8
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort results", {result_hi, result_lo}, 32'd0);
        check("abort flags", {30'd0, div_zero, ovf}, 32'd0);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done || busy) seen++;
        end
        check("no done after abort", 32'(seen), 32'd0);
        do_op("mul 9*9 after reset", 1'b0, 16'h0009, 16'h0009, 16'h0000, 16'h0051, 1'b0, 1'b0, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Iterative 16-bit signed multiply/divide unit in the EX stage, beside the 16-bit adder.
- Takes the same two operands (in1, in2) and produces a 32-bit result pair: product, or quotient plus remainder.
- One operation at a time, with a start/busy/done handshake; the pipeline stalls on busy.

Parameters:
- WIDTH, 16, operand width; results are 2*WIDTH bits total.
- CNT_W, 5, width of the iteration counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
- in1  input  WIDTH  multiplicand / dividend, two's complement.
- in2  input  WIDTH  multiplier / divisor, two's complement.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- result_hi  output  WIDTH  product[31:16] / remainder.
- result_lo  output  WIDTH  product[15:0] / quotient.
- div_zero  output  1  divide with in2 == 0; valid with done.
- ovf  output  1  divide of most-negative by -1; valid with done.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; busy = 0; done = 0; result_hi = 0; result_lo = 0; div_zero = 0; ovf = 0; counter = 0.
- Reset asserted mid-operation aborts immediately to these values. No done is produced for the aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start = 1 latches op, |in1|, |in2| and both sign bits, and clears div_zero/ovf.
  - Next state is RUN, or FIX for the special divide cases below.
  - start = 0 keeps IDLE; results and flags hold their last values.
- RUN: exactly WIDTH cycles, counter counts 0..WIDTH-1.
  - Multiply: unsigned shift-add over the magnitudes, one multiplier bit per cycle.
  - Divide: restoring division over the magnitudes, one quotient bit per cycle.
- FIX: one cycle of sign correction.
  - Product is negated if the sign bits differ.
  - Quotient is negated if the sign bits differ.
  - Remainder takes the sign of the dividend; truncation toward zero.
- DONE: done = 1 for one cycle, busy = 0, next state IDLE.
  - start in DONE is ignored; it must be re-presented in IDLE.
- Latency:
  - Start accepted at edge 0 → busy high from edge 1 → done at edge WIDTH+2 (edge 18 at default).
  - Back-to-back throughput: one operation per WIDTH+3 cycles.
- busy is high in RUN and FIX. A start pulse while busy is ignored and does not disturb the running operation.
- Inputs are needed only in the start cycle; in1/in2 may change freely afterwards.
- Special cases (divide only), decided in IDLE; RUN is skipped and done comes at edge 2:
  - in2 == 0: div_zero = 1, result_lo = 16'hFFFF, result_hi = in1.
  - in1 == 16'h8000 and in2 == 16'hFFFF: ovf = 1, result_lo = 16'h8000, result_hi = 0.
- Multiply never overflows: full 32-bit product. -32768 * -32768 = 32'h4000_0000.
- Arithmetic widths:
  - Internal accumulator is 2*WIDTH+1 bits, so a magnitude of 32768 is representable.
  - Negation is two's complement at full result width.
- Results hold after done until the next accepted start; they are not cleared in IDLE.

Test Plan:
- Reset, then mul 7 * -3 (in1 = 0007, in2 = FFFD) → done at edge 18; hi = FFFF, lo = FFEB, flags 0; busy high on edges 1-17.
- Mul 8000 * 8000 → hi = 4000, lo = 0000. Mul 0000 * FFFF → hi = 0000, lo = 0000.
- Div 100 / 7 → lo = 000E, hi = 0002. Div -100 / 7 (FF9C, 0007) → lo = FFF2, hi = FFFE. Div 100 / -7 → lo = FFF2, hi = 0002.
- Div 1234 / 0 → done at edge 2, div_zero = 1, lo = FFFF, hi = 1234. Div 8000 / FFFF → done at edge 2, ovf = 1, lo = 8000, hi = 0000.
- Start mul 5 * 5; at edge 5 pulse start with div op → ignored, result 0019 at edge 18. Then start immediately in the DONE cycle → ignored; start in IDLE → accepted.
- Start mul 9 * 9; drive rst_n low at edge 8 for half a cycle → all outputs 0 asynchronously, no done pulse; next start runs a normal full operation.
